// File: rtl/lcd_bus_responder_if.sv
// Character-LCD 8-bit bus: the initiator (master) drives EN/RS/RW/DATA_IN,
// the display model (slave) answers with DATA_OUT/DATA_OE during reads.
interface lcd_bus_responder_if;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;

    modport master (output LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
                    input  LCD_DATA_OUT, LCD_DATA_OE);
    modport slave  (input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
                    output LCD_DATA_OUT, LCD_DATA_OE);
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-style display model: 2x16 DDRAM, busy emulation, status/data reads.
// Optional LCD_RESP_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module lcd_bus_responder #(
    parameter int CMD_CYCLES   = 8,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    lcd_bus_responder_if.slave  bus,
    output logic                disp_on,
    output logic [6:0]          cursor_addr,
    output logic                busy,
    input  logic [4:0]          dbg_idx,
    output logic [7:0]          dbg_char,
    output logic [7:0]          drop_cnt
`ifdef LCD_RESP_PROTOCOL_CHECK_EN
    ,
    output logic                proto_err
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    localparam logic [15:0] CMD_LD  = 16'(CMD_CYCLES);
    localparam logic [15:0] CLR_LD  = 16'(CLEAR_CYCLES);
    localparam logic [15:0] TAIL_LD = 16'(CLEAR_CYCLES - 32);

    // {EN, RS, RW, DATA[7:0]} through two flops
    logic [10:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic        en_prev_q, en_prev_d;
    logic        en_s, rs_s, rw_s, strobe, wr_stb, rd_stb;
    logic [7:0]  dat_s;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  fill_q, fill_d;
    logic        rst_fill_q, rst_fill_d;
    logic [6:0]  cursor_q, cursor_d;
    logic        id_q, id_d;
    logic        disp_q, disp_d;
    logic [7:0]  drop_q, drop_d;

    logic [7:0]  ddram_q [32];
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [7:0]  mem_wd;
    logic [4:0]  idx;

    assign en_s   = sync2_q[10];
    assign rs_s   = sync2_q[9];
    assign rw_s   = sync2_q[8];
    assign dat_s  = sync2_q[7:0];
    assign strobe = en_prev_q & ~en_s;
    assign wr_stb = strobe & ~rw_s;
    assign rd_stb = strobe & rw_s;
    assign idx    = {cursor_q[6], cursor_q[3:0]};

    // Line wrap: 0x0F <-> 0x40 and 0x4F <-> 0x00
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) return (a[3:0] == 4'hF) ? {~a[6], 6'h00} : a + 7'd1;
        else     return (a[3:0] == 4'h0) ? {~a[6], 6'h0F} : a - 7'd1;
    endfunction

    always_comb begin
        sync1_d    = {bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA_IN};
        sync2_d    = sync1_q;
        en_prev_d  = en_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        rst_fill_d = rst_fill_q;
        cursor_d   = cursor_q;
        id_d       = id_q;
        disp_d     = disp_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        mem_wa     = idx;
        mem_wd     = dat_s;
        unique case (state_q)
            IDLE: begin
                if (wr_stb) begin
                    state_d = EXEC;
                    cnt_d   = CMD_LD;
                    if (rs_s) begin
                        mem_we   = 1'b1;
                        cursor_d = step_addr(cursor_q, id_q);
                    end else if (dat_s[7]) begin
                        cursor_d = {dat_s[6], 2'b00, dat_s[3:0]};
                    end else if (dat_s[6:4] != 3'b000) begin
                        // CGRAM address, function set and shift are accepted as no-ops
                    end else if (dat_s[3]) begin
                        disp_d = dat_s[2];
                    end else if (dat_s[2]) begin
                        id_d = dat_s[1];
                    end else if (dat_s[1]) begin
                        cursor_d = 7'h00;
                        cnt_d    = CLR_LD;
                    end else if (dat_s[0]) begin
                        state_d  = CLEAR;
                        fill_d   = 5'd0;
                        cursor_d = 7'h00;
                        id_d     = 1'b1;
                    end
                end else if (rd_stb && rs_s) begin
                    cursor_d = step_addr(cursor_q, id_q);
                end
            end
            EXEC: begin
                if (cnt_q <= 16'd1) state_d = IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = fill_q;
                mem_wd = 8'h20;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31) begin
                    // The post-reset fill returns straight to IDLE; a commanded
                    // clear keeps busy for the remainder of CLEAR_CYCLES.
                    rst_fill_d = 1'b0;
                    if (rst_fill_q || TAIL_LD == 16'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = TAIL_LD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_stb && state_q != IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            en_prev_q  <= 1'b0;
            state_q    <= CLEAR;
            cnt_q      <= '0;
            fill_q     <= '0;
            rst_fill_q <= 1'b1;
            cursor_q   <= '0;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            en_prev_q  <= en_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            rst_fill_q <= rst_fill_d;
            cursor_q   <= cursor_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            drop_q     <= drop_d;
        end
    end

    // DDRAM has no reset port; the CLEAR fill after reset initialises it
    always_ff @(posedge CLOCK_50) begin
        if (mem_we && !reset) ddram_q[mem_wa] <= mem_wd;
    end

    assign busy             = (state_q != IDLE);
    assign disp_on          = disp_q;
    assign cursor_addr      = cursor_q;
    assign drop_cnt         = drop_q;
    assign dbg_char         = ddram_q[dbg_idx];
    assign bus.LCD_DATA_OE  = en_s & rw_s;
    assign bus.LCD_DATA_OUT = !(en_s & rw_s) ? 8'h00 :
                              rs_s ? ddram_q[idx] : {busy, cursor_q};

`ifdef LCD_RESP_PROTOCOL_CHECK_EN
    logic       proto_q, proto_d;
    logic [9:0] ctl_prev_q, ctl_prev_d;
    logic [1:0] hi_cnt_q, hi_cnt_d;

    always_comb begin
        ctl_prev_d = sync2_q[9:0];
        hi_cnt_d   = !en_s ? 2'd0 : (hi_cnt_q == 2'd3) ? 2'd3 : hi_cnt_q + 2'd1;
        proto_d    = proto_q;
        // ctl_prev_q[8] is RW: only write cycles must hold RS/RW/DATA steady
        if (en_s && en_prev_q && !ctl_prev_q[8] && sync2_q[9:0] != ctl_prev_q) proto_d = 1'b1;
        if (strobe && hi_cnt_q < 2'd2) proto_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            proto_q    <= 1'b0;
            ctl_prev_q <= '0;
            hi_cnt_q   <= '0;
        end else begin
            proto_q    <= proto_d;
            ctl_prev_q <= ctl_prev_d;
            hi_cnt_q   <= hi_cnt_d;
        end
    end

    assign proto_err = proto_q;
`endif
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: writes, commands, busy timing, reads, reset.
module tb_lcd_bus_responder;
    localparam int CMD_CYCLES   = 8;
    localparam int CLEAR_CYCLES = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_on;
    logic [6:0] cursor_addr;
    logic       busy;
    logic [4:0] dbg_idx;
    logic [7:0] dbg_char;
    logic [7:0] drop_cnt;
`ifdef LCD_RESP_PROTOCOL_CHECK_EN
    logic       proto_err;
`endif
    int total = 0;
    int bad   = 0;
    int run      = 0;
    int last_run = 0;

    always #10 clk = ~clk;

    lcd_bus_responder_if bus ();

    lcd_bus_responder #(.CMD_CYCLES(CMD_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .bus         (bus),
        .disp_on     (disp_on),
        .cursor_addr (cursor_addr),
        .busy        (busy),
        .dbg_idx     (dbg_idx),
        .dbg_char    (dbg_char),
        .drop_cnt    (drop_cnt)
`ifdef LCD_RESP_PROTOCOL_CHECK_EN
        ,
        .proto_err   (proto_err)
`endif
    );

    // Length of the most recent completed busy period, in clock cycles
    always @(negedge clk) begin
        if (busy) run++;
        else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b0; bus.LCD_DATA_IN = d;
        cyc(3);
        bus.LCD_EN = 1'b1;
        cyc(4);
        bus.LCD_EN = 1'b0;
        cyc(4);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
        cyc(1);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        lcd_write(rs, d);
        wait_idle("wait_idle");
    endtask

    task automatic lcd_read(input logic rs, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b1;
        cyc(3);
        bus.LCD_EN = 1'b1;
        cyc(4);
        chk({tag, "_oe"}, {31'd0, bus.LCD_DATA_OE}, 32'd1);
        chk(tag, {24'd0, bus.LCD_DATA_OUT}, {24'd0, exp});
        bus.LCD_EN = 1'b0;
        cyc(4);
        bus.LCD_RW = 1'b0;
    endtask

    task automatic chk_ram(input int i, input logic [7:0] exp, input string tag);
        dbg_idx = i[4:0];
        #1;
        chk(tag, {24'd0, dbg_char}, {24'd0, exp});
    endtask

    logic [7:0] msg [8] = '{8'h43, 8'h6F, 8'h72, 8'h72, 8'h65, 8'h74, 8'h6F, 8'h21};

    initial begin
        reset = 1'b1; dbg_idx = '0;
        bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA_IN = '0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("busy_rst_fill", {31'd0, busy}, 32'd1);
        wait_idle("rst_idle");
        for (int i = 0; i < 32; i++) chk_ram(i, 8'h20, "ram_rst");
        chk("cursor_rst", {25'd0, cursor_addr}, 32'h00);
        chk("disp_rst", {31'd0, disp_on}, 32'd0);
        chk("drop_rst", {24'd0, drop_cnt}, 32'd0);
        chk("out_rst", {24'd0, bus.LCD_DATA_OUT}, 32'h00);
        chk("oe_rst", {31'd0, bus.LCD_DATA_OE}, 32'd0);

        wr(1'b0, 8'h01);
        wr(1'b0, 8'h0F);
        for (int i = 0; i < 8; i++) wr(1'b1, msg[i]);
        for (int i = 0; i < 8; i++) chk_ram(i, msg[i], "ram_msg");
        chk("disp_on", {31'd0, disp_on}, 32'd1);
        chk("cursor_msg", {25'd0, cursor_addr}, 32'h08);
        chk("run_data", last_run, CMD_CYCLES);

        wr(1'b0, 8'h8F);
        wr(1'b1, 8'h41);
        wr(1'b1, 8'h42);
        chk_ram(15, 8'h41, "ram15");
        chk_ram(16, 8'h42, "ram16");
        chk("cursor_l2", {25'd0, cursor_addr}, 32'h41);
        wr(1'b0, 8'hCF);
        wr(1'b1, 8'h5A);
        chk_ram(31, 8'h5A, "ram31");
        chk("cursor_wrap", {25'd0, cursor_addr}, 32'h00);

        wr(1'b0, 8'h04);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h31);
        chk_ram(0, 8'h31, "ram_dec");
        chk("cursor_dec", {25'd0, cursor_addr}, 32'h4F);
        wr(1'b0, 8'h06);

        wr(1'b0, 8'h85);
        wr(1'b0, 8'h02);
        chk("cursor_home", {25'd0, cursor_addr}, 32'h00);
        chk("run_home", last_run, CLEAR_CYCLES);

        lcd_write(1'b0, 8'h01);
        lcd_write(1'b1, 8'h55);
        chk("drop_busy", {24'd0, drop_cnt}, 32'd1);
        lcd_read(1'b0, 8'h80, "status_busy");
        wait_idle("clr_idle");
        chk("run_clear", last_run, CLEAR_CYCLES);
        chk_ram(0, 8'h20, "ram_drop");
        chk_ram(8, 8'h20, "ram_clr8");
        chk("cursor_drop", {25'd0, cursor_addr}, 32'h00);

        wr(1'b0, 8'h85);
        lcd_read(1'b0, 8'h05, "status_idle");
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h43);
        wr(1'b0, 8'h80);
        lcd_read(1'b1, 8'h43, "data_read");
        chk("cursor_rd", {25'd0, cursor_addr}, 32'h01);
        chk("busy_rd", {31'd0, busy}, 32'd0);

        wr(1'b0, 8'hCF);
        wr(1'b1, 8'h77);
        lcd_write(1'b0, 8'h01);
        cyc(8);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("busy_refill", {31'd0, busy}, 32'd1);
        chk_ram(31, 8'h77, "ram31_pre_fill");
        wait_idle("refill_idle");
        for (int i = 0; i < 32; i++) chk_ram(i, 8'h20, "ram_refill");
        chk("drop_reset", {24'd0, drop_cnt}, 32'd0);
        chk("cursor_reset", {25'd0, cursor_addr}, 32'h00);
        chk("disp_reset", {31'd0, disp_on}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
